// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with per-scan debounce and one code per press.
// Optional entered-number register (digit3..digit0) enabled by defining KEYPAD_DIGITS_EN.
module keypad_scanner #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
`ifdef KEYPAD_DIGITS_EN
    ,
    output logic [3:0] digit3,
    output logic [3:0] digit2,
    output logic [3:0] digit1,
    output logic [3:0] digit0
`endif
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PRESS_DB = 2'd1,
        S_HELD     = 2'd2,
        S_REL_DB   = 2'd3
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [PW-1:0]   presc_r;
    logic [1:0]      col_idx_r;
    logic [1:0]      col_idx_nxt_s;
    logic [3:0]      col_r;
    logic [11:0]     map_r;
    logic [CW-1:0]   cnt_r, cnt_inc_s, cnt_nxt_s;
    logic [4:0]      cand_prev_r;
    logic [4:0]      cand_s;
    logic [15:0]     full_map_s;
    logic [3:0]      key_code_r;
    logic            key_valid_r;
    logic            key_held_r;
    logic            tick_s, scan_done_s, same_prev_s, is_key_s;
    logic            accept_s, release_s;

    // Key legend for row r / column c, packed as {r, c}
    function automatic logic [3:0] key_lut(input logic [3:0] rc);
        logic [3:0] code;
        case (rc)
            4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
            4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
            4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
            4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  4'hF: code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    // Map bit index is col*4+row; a chord or empty map yields NONE (valid bit clear)
    function automatic logic [4:0] decode_scan(input logic [15:0] m);
        logic [4:0] ones;
        logic [3:0] idx;
        logic [4:0] res;
        ones = 5'd0;
        idx  = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (m[i]) begin
                ones = ones + 5'd1;
                idx  = 4'(i);
            end else begin
                ones = ones;
            end
        end
        if (ones == 5'd1) begin
            res = {1'b1, key_lut({idx[1:0], idx[3:2]})};
        end else begin
            res = 5'd0;
        end
        return res;
    endfunction

    assign tick_s        = (presc_r == PW'(SCAN_DIV - 1));
    assign scan_done_s   = tick_s && (col_idx_r == 2'd3);
    assign col_idx_nxt_s = col_idx_r + 2'd1;
    assign full_map_s    = {~row, map_r};
    assign cand_s        = decode_scan(full_map_s);
    assign is_key_s      = cand_s[4];
    assign same_prev_s   = (cand_s == cand_prev_r);
    assign cnt_inc_s     = (cnt_r >= CW'(DEBOUNCE_SCANS)) ? cnt_r : cnt_r + CW'(1);

    // Prescaler, column walk and per-column row capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r   <= '0;
            col_idx_r <= 2'd0;
            col_r     <= 4'b1110;
            map_r     <= 12'd0;
        end else if (tick_s) begin
            presc_r   <= '0;
            col_idx_r <= col_idx_nxt_s;
            col_r     <= ~(4'b0001 << col_idx_nxt_s);
            case (col_idx_r)
                2'd0:    map_r[3:0]  <= ~row;
                2'd1:    map_r[7:4]  <= ~row;
                2'd2:    map_r[11:8] <= ~row;
                default: map_r       <= map_r;
            endcase
        end else begin
            presc_r   <= presc_r + PW'(1);
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state, evaluated only on the tick that closes a full scan
    always_comb begin
        state_nxt_s = state_r;
        if (scan_done_s) begin
            case (state_r)
                S_IDLE: begin
                    if (is_key_s) begin
                        state_nxt_s = (DEBOUNCE_SCANS == 1) ? S_HELD : S_PRESS_DB;
                    end else begin
                        state_nxt_s = S_IDLE;
                    end
                end
                S_PRESS_DB: begin
                    if (!is_key_s) begin
                        state_nxt_s = S_IDLE;
                    end else if (same_prev_s && (cnt_inc_s == CW'(DEBOUNCE_SCANS))) begin
                        state_nxt_s = S_HELD;
                    end else begin
                        state_nxt_s = S_PRESS_DB;
                    end
                end
                S_HELD: begin
                    if (cand_s != {1'b1, key_code_r}) begin
                        state_nxt_s = (DEBOUNCE_SCANS == 1) ? S_IDLE : S_REL_DB;
                    end else begin
                        state_nxt_s = S_HELD;
                    end
                end
                S_REL_DB: begin
                    if (cand_s == {1'b1, key_code_r}) begin
                        state_nxt_s = S_HELD;
                    end else if (same_prev_s && (cnt_inc_s == CW'(DEBOUNCE_SCANS))) begin
                        state_nxt_s = S_IDLE;
                    end else begin
                        state_nxt_s = S_REL_DB;
                    end
                end
                default: state_nxt_s = S_IDLE;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // FSM outputs: accept/release strobes and debounce count update
    always_comb begin
        accept_s  = 1'b0;
        release_s = 1'b0;
        cnt_nxt_s = cnt_r;
        if (scan_done_s) begin
            case (state_r)
                S_IDLE: begin
                    accept_s  = is_key_s && (DEBOUNCE_SCANS == 1);
                    cnt_nxt_s = CW'(1);
                end
                S_PRESS_DB: begin
                    accept_s  = is_key_s && same_prev_s && (cnt_inc_s == CW'(DEBOUNCE_SCANS));
                    cnt_nxt_s = same_prev_s ? cnt_inc_s : CW'(1);
                end
                S_HELD: begin
                    release_s = (cand_s != {1'b1, key_code_r}) && (DEBOUNCE_SCANS == 1);
                    cnt_nxt_s = CW'(1);
                end
                S_REL_DB: begin
                    release_s = (cand_s != {1'b1, key_code_r}) && same_prev_s &&
                                (cnt_inc_s == CW'(DEBOUNCE_SCANS));
                    cnt_nxt_s = same_prev_s ? cnt_inc_s : CW'(1);
                end
                default: cnt_nxt_s = CW'(1);
            endcase
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Debounce counter, previous-scan candidate and reported key registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r       <= '0;
            cand_prev_r <= 5'd0;
            key_code_r  <= 4'd0;
            key_valid_r <= 1'b0;
            key_held_r  <= 1'b0;
        end else begin
            cnt_r       <= cnt_nxt_s;
            cand_prev_r <= scan_done_s ? cand_s : cand_prev_r;
            key_code_r  <= accept_s ? cand_s[3:0] : key_code_r;
            key_valid_r <= accept_s;
            if (accept_s) begin
                key_held_r <= 1'b1;
            end else if (release_s) begin
                key_held_r <= 1'b0;
            end else begin
                key_held_r <= key_held_r;
            end
        end
    end

    assign col       = col_r;
    assign key_code  = key_code_r;
    assign key_valid = key_valid_r;
    assign key_held  = key_held_r;

`ifdef KEYPAD_DIGITS_EN
    logic [3:0] digit3_r, digit2_r, digit1_r, digit0_r;

    // Entered-number register: decimal keys shift in, E clears, letters are ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit3_r <= 4'd0;
            digit2_r <= 4'd0;
            digit1_r <= 4'd0;
            digit0_r <= 4'd0;
        end else if (accept_s && (cand_s[3:0] <= 4'd9)) begin
            digit3_r <= digit2_r;
            digit2_r <= digit1_r;
            digit1_r <= digit0_r;
            digit0_r <= cand_s[3:0];
        end else if (accept_s && (cand_s[3:0] == 4'hE)) begin
            digit3_r <= 4'd0;
            digit2_r <= 4'd0;
            digit1_r <= 4'd0;
            digit0_r <= 4'd0;
        end else begin
            digit3_r <= digit3_r;
            digit2_r <= digit2_r;
            digit1_r <= digit1_r;
            digit0_r <= digit0_r;
        end
    end

    assign digit3 = digit3_r;
    assign digit2 = digit2_r;
    assign digit1 = digit1_r;
    assign digit0 = digit0_r;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=2, one scan = 16 clk).
module tb_keypad_scanner;

    localparam logic [15:0] K1 = 16'h0001, K2 = 16'h0002, K3 = 16'h0004, KA = 16'h0008;
    localparam logic [15:0] K4 = 16'h0010, K5 = 16'h0020, K6 = 16'h0040;
    localparam logic [15:0] KS = 16'h1000, K0 = 16'h2000, KD = 16'h8000;

    typedef struct {
        logic [15:0] mask;
        int          scans;
        logic [3:0]  code;
        logic        held;
        int          pulses;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] row, col, key_code;
    logic       key_valid, key_held;
    logic [15:0] mask = 16'd0;   // pressed keys, bit r*4+c
`ifdef KEYPAD_DIGITS_EN
    logic [3:0] digit3, digit2, digit1, digit0;
`endif

    int   checks = 0;
    int   errors = 0;
    int   vcnt = 0;
    logic vprev = 1'b0;
    logic consec = 1'b0;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
        .clk(clk), .rst_n(rst_n), .row(row), .col(col),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
`ifdef KEYPAD_DIGITS_EN
        , .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0)
`endif
    );

    always #5 clk = ~clk;

    // Passive keypad: a row reads low when a pressed key sits on the driven-low column
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            row[r] = ~|(mask[r*4 +: 4] & ~col);
        end
    end

    // Count key_valid pulses and flag any back-to-back pulse
    always @(posedge clk) begin
        if (key_valid) vcnt <= vcnt + 1;
        if (key_valid && vprev) consec <= 1'b1;
        vprev <= key_valid;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_scans(input int n);
        repeat (16 * n) @(posedge clk);
        @(negedge clk);
    endtask

`ifdef KEYPAD_DIGITS_EN
    task automatic press(input logic [15:0] k);
        mask = k;
        run_scans(3);
        mask = 16'd0;
        run_scans(2);
    endtask
`endif

    vec_t tbl[17];

    initial begin
        int v0;
        logic [3:0] ecol;

        tbl[0]  = '{K6,      3, 4'h6, 1'b1, 1};
        tbl[1]  = '{16'd0,   1, 4'h6, 1'b1, 0};
        tbl[2]  = '{16'd0,   1, 4'h6, 1'b0, 0};
        tbl[3]  = '{K1,      1, 4'h6, 1'b0, 0};
        tbl[4]  = '{16'd0,   1, 4'h6, 1'b0, 0};
        tbl[5]  = '{K1,      1, 4'h6, 1'b0, 0};
        tbl[6]  = '{K1,      2, 4'h1, 1'b1, 1};
        tbl[7]  = '{16'd0,   1, 4'h1, 1'b1, 0};
        tbl[8]  = '{K1,      1, 4'h1, 1'b1, 0};
        tbl[9]  = '{16'd0,   2, 4'h1, 1'b0, 0};
        tbl[10] = '{K1 | K5, 3, 4'h1, 1'b0, 0};
        tbl[11] = '{K2,      3, 4'h2, 1'b1, 1};
        tbl[12] = '{K3,      2, 4'h2, 1'b0, 0};
        tbl[13] = '{K3,      3, 4'h3, 1'b1, 1};
        tbl[14] = '{16'd0,   2, 4'h3, 1'b0, 0};
        tbl[15] = '{KD,      3, 4'hD, 1'b1, 1};
        tbl[16] = '{16'd0,   2, 4'hD, 1'b0, 0};

        repeat (2) @(negedge clk);
        chk("reset_col", col, 4'b1110);
        chk("reset_code", key_code, 4'h0);
        chk("reset_valid", key_valid, 1'b0);
        chk("reset_held", key_held, 1'b0);
        rst_n = 1'b1;

        for (int k = 0; k < 32; k++) begin
            ecol = ~(4'b0001 << ((k / 4) % 4));
            chk($sformatf("col_walk_%0d", k), col, ecol);
            @(posedge clk);
            @(negedge clk);
        end
        chk("idle_no_valid", vcnt, 0);

        for (int i = 0; i < 17; i++) begin
            mask = tbl[i].mask;
            v0 = vcnt;
            run_scans(tbl[i].scans);
            chk($sformatf("vec%0d_code", i), key_code, tbl[i].code);
            chk($sformatf("vec%0d_held", i), key_held, tbl[i].held);
            chk($sformatf("vec%0d_pulses", i), vcnt - v0, tbl[i].pulses);
        end

`ifdef KEYPAD_DIGITS_EN
        press(K1); press(K2); press(K3); press(K4); press(K5);
        chk("digits_shift", {digit3, digit2, digit1, digit0}, 16'h2345);
        press(KA);
        chk("digits_letter", {digit3, digit2, digit1, digit0}, 16'h2345);
        chk("digits_letter_code", key_code, 4'hA);
        press(KS);
        chk("digits_clear", {digit3, digit2, digit1, digit0}, 16'h0000);
        chk("digits_clear_code", key_code, 4'hE);
`endif

        mask = K0;
        v0 = vcnt;
        run_scans(3);
        chk("pre_rst_held", key_held, 1'b1);
        chk("pre_rst_pulses", vcnt - v0, 1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_held", key_held, 1'b0);
        chk("midrst_col", col, 4'b1110);
        chk("midrst_valid", key_valid, 1'b0);
        chk("midrst_code", key_code, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        v0 = vcnt;
        run_scans(3);
        chk("post_rst_code", key_code, 4'h0);
        chk("post_rst_held", key_held, 1'b1);
        chk("post_rst_pulses", vcnt - v0, 1);
        chk("no_consecutive_valid", consec, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
